layer_output_serializer: RTL and testbench
==========================================

// Module: layer_output_serializer
// PURPOSE
//   Sits between two fully-connected layers. Captures the NN parallel neuron results
//   from one layer in a single cycle and replays them as a serial stream of
//   dataWidth-bit words into the next layer's shared x_valid/x_in input.
//   Provides one-vector buffering plus sticky error flags for overruns and for
//   partial valid vectors.
// PARAMETERS
//   NN         30   number of neurons in the upstream layer = words per vector
//   dataWidth  16   width of one neuron output / one stream word
// PORTS
//   clk          in   1              single clock, rising edge
//   rst          in   1              asynchronous, active-low reset
//   in_valid     in   NN             per-neuron output valid from upstream layer
//   in_data      in   NN*dataWidth   neuron k result at in_data[k*dataWidth+:dataWidth]
//   err_clr      in   1              synchronous clear of overrun/partial_err
//   out_valid    out  1              stream word valid; drives next layer x_valid
//   out_data     out  dataWidth      stream word; drives next layer x_in
//   out_last     out  1              high with the word from neuron NN-1
//   busy         out  1              high while a vector is being replayed
//   overrun      out  1              sticky: a vector arrived while busy and was dropped
//   partial_err  out  1              sticky: in_valid was nonzero but not all-ones
// BEHAVIOUR
// - Reset (rst=0, async):
//   - state=IDLE, count=0.
//   - out_valid, out_last, busy, overrun, partial_err = 0; out_data = 0.
//   - Capture register is cleared.
// - Capture trigger:
//   - cap = (&in_valid) && (state==IDLE || (state==SHIFT && count==NN-1)).
//   - On cap, all NN words are latched into the capture register at that edge.
// - FSM states:
//   - IDLE: no words in flight.
//   - SHIFT: replaying a captured vector.
// - FSM transitions:
//   - IDLE --cap--> SHIFT, count=0.
//   - SHIFT, count<NN-1: count++ each cycle, no stalls (downstream has no ready).
//   - SHIFT, count==NN-1, cap: stay in SHIFT, count=0 (back-to-back vectors, no bubble).
//   - SHIFT, count==NN-1, !cap: go to IDLE.
// - Output timing (registered):
//   - Vector captured at edge T: word k appears on out_data with out_valid=1 in
//     cycle T+1+k, for k=0..NN-1.
//   - Word k = in_data[k*dataWidth+:dataWidth] as sampled at edge T.
//   - out_last=1 only for k=NN-1. out_data holds its last value when out_valid=0.
//   - busy = (state==SHIFT).
// - Overrun:
//   - &in_valid while SHIFT and count!=NN-1: vector is dropped and overrun is set.
//   - The replay in progress is not disturbed.
// - Partial vector:
//   - |in_valid && !&in_valid: no capture, partial_err set, in any state.
// - Error flags:
//   - overrun and partial_err hold until err_clr=1 or reset.
//   - If a set event and err_clr coincide in one cycle, the set wins.
// - Width rules: pure data movement, no arithmetic or sign change on words.
//   count is $clog2(NN) bits wide (minimum 1).
// - Reset mid-replay: aborts immediately; remaining words are never emitted.
//   After release, only a fresh &in_valid restarts the stream.
// TESTING
// - Vector with word k = 16'h0100+k, in_valid all-ones at T -> out_valid cycles
//   T+1..T+30 give 0100..011D in order; out_last only at T+30; busy low at T+31.
// - Second full vector exactly at the edge where count==29 -> 60 contiguous
//   out_valid cycles, second sequence intact, overrun=0.
// - Second full vector at count==10 -> first stream completes unchanged, second
//   is never emitted, overrun=1 until err_clr pulse, then 0.
// - in_valid=30'h0000_0001 in IDLE -> no out_valid, partial_err=1, busy stays 0;
//   err_clr together with a new partial -> partial_err stays 1.
// - rst low for one cycle at count==15 -> outputs 0 asynchronously; no further
//   words after release until a new full vector is applied.
// - NN=1 build: one-word vectors on consecutive cycles -> out_valid continuously
//   high, out_last=1 every cycle, no overrun.

Source files
------------

// File: rtl/layer_output_serializer.sv
// layer_output_serializer
//   Captures a full vector of NN neuron results in one cycle and replays it as a
//   serial stream of dataWidth-bit words, one per cycle, for the next layer.
//   Holds one vector while it is being replayed. A new vector can be captured on the
//   same edge that the last word goes out, so back-to-back vectors have no gap.
//   Sticky flags report vectors dropped while busy and partially valid vectors.
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_valid     per-neuron valid; a vector is accepted only when all bits are set
//   in_data      neuron k result at in_data[k*dataWidth +: dataWidth]
//   err_clr      synchronous clear of overrun / partial_err (a set in the same cycle wins)
//   out_valid    stream word valid (drives next layer x_valid)
//   out_data     stream word (drives next layer x_in); holds its value when idle
//   out_last     marks the word from neuron NN-1
//   busy         a vector is being replayed
//   overrun      sticky: full vector arrived mid-replay and was dropped
//   partial_err  sticky: in_valid was nonzero but not all-ones
module layer_output_serializer #(
  parameter int unsigned NN        = 30,
  parameter int unsigned dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           in_valid,
  input  logic [NN*dataWidth-1:0] in_data,
  input  logic                    err_clr,
  output logic                    out_valid,
  output logic [dataWidth-1:0]    out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun,
  output logic                    partial_err
);

  localparam int unsigned    CntW    = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NN - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         count_q;  // index of the word currently on out_data
  logic [NN*dataWidth-1:0] cap_q;    // words not yet emitted, next one in the low slot

  logic vec_full;
  logic vec_any;
  logic at_last;
  logic cap;
  logic overrun_set;
  logic partial_set;

  always_comb begin
    vec_full    = &in_valid;
    vec_any     = |in_valid;
    at_last     = (state_q == StShift) && (count_q == LastIdx);
    cap         = vec_full && ((state_q == StIdle) || at_last);
    overrun_set = vec_full && (state_q == StShift) && !at_last;
    partial_set = vec_any && !vec_full;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      cap_q       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      partial_err <= 1'b0;
    end else begin
      overrun     <= overrun_set | (overrun & ~err_clr);
      partial_err <= partial_set | (partial_err & ~err_clr);

      if (cap) begin
        // Word 0 goes straight out; the rest are parked already shifted down by one slot.
        state_q   <= StShift;
        count_q   <= '0;
        cap_q     <= in_data >> dataWidth;
        out_valid <= 1'b1;
        busy      <= 1'b1;
        out_data  <= in_data[dataWidth-1:0];
        out_last  <= (NN == 1);
      end else if ((state_q == StShift) && !at_last) begin
        count_q  <= count_q + 1'b1;
        cap_q    <= cap_q >> dataWidth;
        out_data <= cap_q[dataWidth-1:0];
        out_last <= ((count_q + 1'b1) == LastIdx);
      end else begin
        state_q   <= StIdle;
        count_q   <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_layer_output_serializer.sv
module tb_layer_output_serializer;

  localparam int NN = 30;
  localparam int W  = 16;

  logic            clk;
  logic            rst;
  logic [NN-1:0]   in_valid;
  logic [NN*W-1:0] in_data;
  logic            err_clr;
  logic            out_valid, out_last, busy, overrun, partial_err;
  logic [W-1:0]    out_data;

  logic            in_valid1;
  logic [W-1:0]    in_data1;
  logic            out_valid1, out_last1, busy1, overrun1, partial_err1;
  logic [W-1:0]    out_data1;

  int n_chk;
  int n_fail;

  // Reference model: queue of words still to be emitted plus the visible output word.
  logic [W:0]   pend[$];
  logic         m_valid, m_last, m_ovr, m_part;
  logic [W-1:0] m_data;

  layer_output_serializer #(.NN(NN), .dataWidth(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .err_clr(err_clr),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy),
    .overrun(overrun), .partial_err(partial_err)
  );

  layer_output_serializer #(.NN(1), .dataWidth(W)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .err_clr(err_clr),
    .out_valid(out_valid1), .out_data(out_data1), .out_last(out_last1), .busy(busy1),
    .overrun(overrun1), .partial_err(partial_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    pend.delete();
    m_valid = 1'b0; m_last = 1'b0; m_ovr = 1'b0; m_part = 1'b0; m_data = '0;
  endtask

  // Apply one clock edge to the model using the inputs currently presented.
  task automatic model_edge();
    logic [W:0] e;
    bit full, any, ovr_set, part_set;
    full     = &in_valid;
    any      = |in_valid;
    ovr_set  = full && (pend.size() != 0);
    part_set = any && !full;
    if (full && pend.size() == 0)
      for (int k = 0; k < NN; k++) pend.push_back({(k == NN - 1), in_data[k*W +: W]});
    m_ovr  = ovr_set || (m_ovr && !err_clr);
    m_part = part_set || (m_part && !err_clr);
    if (pend.size() > 0) begin
      e = pend.pop_front();
      m_valid = 1'b1; m_last = e[W]; m_data = e[W-1:0];
    end else begin
      m_valid = 1'b0; m_last = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [NN*W-1:0] rand_vec();
    logic [NN*W-1:0] v;
    for (int k = 0; k < NN; k++) v[k*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk);
    n_chk++;
    if ({out_valid, busy, out_last, out_data, overrun, partial_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b b=%b l=%b d=%h o=%b p=%b want all zero",
               out_valid, busy, out_last, out_data, overrun, partial_err);
    end
    rst = 1'b1;
  endtask

  task automatic test_single_vector();
    for (int k = 0; k < NN; k++) in_data[k*W +: W] = W'(16'h0100 + k);
    in_valid = '1;
    for (int c = 0; c < NN + 2; c++) begin
      cycle();
      in_valid = '0;
      n_chk++;
      if ({out_valid, busy, out_last, out_data, overrun, partial_err} !==
          {m_valid, m_valid, m_last, m_data, m_ovr, m_part}) begin
        n_fail++;
        $display("FAIL single c=%0d got v=%b b=%b l=%b d=%h o=%b p=%b want v=%b l=%b d=%h o=%b p=%b",
                 c, out_valid, busy, out_last, out_data, overrun, partial_err,
                 m_valid, m_last, m_data, m_ovr, m_part);
      end
      if (c == 0) begin
        n_chk++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 16'h0100}) begin
          n_fail++;
          $display("FAIL single_first got v=%b l=%b d=%h want v=1 l=0 d=0100",
                   out_valid, out_last, out_data);
        end
      end
      if (c == NN - 1) begin
        n_chk++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 16'h011D}) begin
          n_fail++;
          $display("FAIL single_last got v=%b l=%b d=%h want v=1 l=1 d=011d",
                   out_valid, out_last, out_data);
        end
      end
      if (c == NN) begin
        n_chk++;
        if ({busy, out_valid} !== 2'b00) begin
          n_fail++;
          $display("FAIL single_idle got busy=%b v=%b want 0 0", busy, out_valid);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int vcnt, gaps;
    vcnt = 0; gaps = 0;
    in_data  = rand_vec();
    in_valid = '1;
    for (int c = 0; c < 2 * NN + 2; c++) begin
      cycle();
      in_valid = '0;
      n_chk++;
      if ({out_valid, busy, out_last, out_data, overrun, partial_err} !==
          {m_valid, m_valid, m_last, m_data, m_ovr, m_part}) begin
        n_fail++;
        $display("FAIL b2b c=%0d got v=%b b=%b l=%b d=%h o=%b p=%b want v=%b l=%b d=%h o=%b p=%b",
                 c, out_valid, busy, out_last, out_data, overrun, partial_err,
                 m_valid, m_last, m_data, m_ovr, m_part);
      end
      if (out_valid) vcnt++;
      else if (c < 2 * NN) gaps++;
      if (c == NN - 1) begin
        in_data  = rand_vec();
        in_valid = '1;
      end
    end
    n_chk++;
    if (vcnt != 2 * NN || gaps != 0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_summary got words=%0d gaps=%0d overrun=%b want words=%0d gaps=0 overrun=0",
               vcnt, gaps, overrun, 2 * NN);
    end
  endtask

  task automatic test_overrun();
    int vcnt;
    vcnt = 0;
    in_data  = rand_vec();
    in_valid = '1;
    for (int c = 0; c < NN + 3; c++) begin
      cycle();
      in_valid = '0;
      n_chk++;
      if ({out_valid, busy, out_last, out_data, overrun, partial_err} !==
          {m_valid, m_valid, m_last, m_data, m_ovr, m_part}) begin
        n_fail++;
        $display("FAIL overrun c=%0d got v=%b b=%b l=%b d=%h o=%b p=%b want v=%b l=%b d=%h o=%b p=%b",
                 c, out_valid, busy, out_last, out_data, overrun, partial_err,
                 m_valid, m_last, m_data, m_ovr, m_part);
      end
      if (out_valid) vcnt++;
      if (c == 10) begin
        in_data  = rand_vec();
        in_valid = '1;
      end
    end
    n_chk++;
    if (vcnt != NN || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_summary got words=%0d overrun=%b want words=%0d overrun=1",
               vcnt, overrun, NN);
    end
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    n_chk++;
    if (overrun !== 1'b0 || overrun !== m_ovr) begin
      n_fail++;
      $display("FAIL overrun_clear got overrun=%b want 0", overrun);
    end
  endtask

  task automatic test_partial();
    in_valid = NN'(1);
    cycle();
    in_valid = '0;
    n_chk++;
    if ({out_valid, busy, partial_err} !== 3'b001 || partial_err !== m_part) begin
      n_fail++;
      $display("FAIL partial_set got v=%b b=%b p=%b want v=0 b=0 p=1",
               out_valid, busy, partial_err);
    end
    err_clr  = 1'b1;
    in_valid = NN'(2);
    cycle();
    in_valid = '0;
    n_chk++;
    if (partial_err !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_set_wins got p=%b v=%b want p=1 v=0", partial_err, out_valid);
    end
    cycle();
    err_clr = 1'b0;
    n_chk++;
    if (partial_err !== 1'b0 || partial_err !== m_part) begin
      n_fail++;
      $display("FAIL partial_clear got p=%b want 0", partial_err);
    end
  endtask

  task automatic test_reset_mid();
    int vcnt;
    vcnt = 0;
    in_data  = rand_vec();
    in_valid = '1;
    for (int c = 0; c <= 15; c++) begin
      cycle();
      in_valid = '0;
      n_chk++;
      if ({out_valid, out_last, out_data} !== {m_valid, m_last, m_data}) begin
        n_fail++;
        $display("FAIL rstmid_pre c=%0d got v=%b l=%b d=%h want v=%b l=%b d=%h",
                 c, out_valid, out_last, out_data, m_valid, m_last, m_data);
      end
    end
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, busy, out_last, out_data, overrun, partial_err} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async got v=%b b=%b l=%b d=%h o=%b p=%b want all zero",
               out_valid, busy, out_last, out_data, overrun, partial_err);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < NN + 5; c++) begin
      cycle();
      if (out_valid) vcnt++;
    end
    n_chk++;
    if (vcnt != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet got words=%0d busy=%b want words=0 busy=0", vcnt, busy);
    end
    in_data  = rand_vec();
    in_valid = '1;
    for (int c = 0; c < NN + 1; c++) begin
      cycle();
      in_valid = '0;
      n_chk++;
      if ({out_valid, busy, out_last, out_data} !== {m_valid, m_valid, m_last, m_data}) begin
        n_fail++;
        $display("FAIL rstmid_restart c=%0d got v=%b l=%b d=%h want v=%b l=%b d=%h",
                 c, out_valid, out_last, out_data, m_valid, m_last, m_data);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [NN-1:0] v;
    for (int i = 0; i < 400 + NN + 2; i++) begin
      in_valid = '0;
      err_clr  = 1'b0;
      if (i < 400) begin
        r = int'($urandom_range(0, 99));
        if (r < 15) begin
          in_data  = rand_vec();
          in_valid = '1;
        end else if (r < 22) begin
          v = NN'($urandom);
          if (v == '0) v = NN'(1);
          if (&v) v[0] = 1'b0;
          in_data  = rand_vec();
          in_valid = v;
        end
        if ($urandom_range(0, 19) == 0) err_clr = 1'b1;
      end else begin
        err_clr = 1'b1;
      end
      cycle();
      n_chk++;
      if ({out_valid, busy, out_last, out_data, overrun, partial_err} !==
          {m_valid, m_valid, m_last, m_data, m_ovr, m_part}) begin
        n_fail++;
        $display("FAIL random i=%0d got v=%b b=%b l=%b d=%h o=%b p=%b want v=%b l=%b d=%h o=%b p=%b",
                 i, out_valid, busy, out_last, out_data, overrun, partial_err,
                 m_valid, m_last, m_data, m_ovr, m_part);
      end
    end
    in_valid = '0;
    err_clr  = 1'b0;
  endtask

  task automatic test_nn1();
    logic [W-1:0] prev;
    prev = '0;
    for (int c = 0; c < 20; c++) begin
      in_data1  = W'($urandom);
      in_valid1 = 1'b1;
      prev      = in_data1;
      cycle();
      n_chk++;
      if ({out_valid1, busy1, out_last1, out_data1, overrun1} !== {1'b1, 1'b1, 1'b1, prev, 1'b0}) begin
        n_fail++;
        $display("FAIL nn1 c=%0d got v=%b b=%b l=%b d=%h o=%b want v=1 b=1 l=1 d=%h o=0",
                 c, out_valid1, busy1, out_last1, out_data1, overrun1, prev);
      end
    end
    in_valid1 = 1'b0;
    cycle();
    n_chk++;
    if ({out_valid1, busy1, out_last1, out_data1} !== {1'b0, 1'b0, 1'b0, prev}) begin
      n_fail++;
      $display("FAIL nn1_idle got v=%b b=%b l=%b d=%h want v=0 b=0 l=0 d=%h",
               out_valid1, busy1, out_last1, out_data1, prev);
    end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    err_clr   = 1'b0;
    in_valid1 = 1'b0;
    in_data1  = '0;
    test_reset();
    test_single_vector();
    test_back_to_back();
    test_overrun();
    test_partial();
    test_reset_mid();
    test_random();
    test_nn1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
